seg_scan_driver: RTL and testbench

Time-multiplexed driver for a NUM_DIGITS-digit common-anode seven-segment display. It replaces the single-digit combinational decoder in the oven front panel.
- Scans digits one at a time and inserts a dead cycle between digits.
- Latches display data atomically on a load strobe.
- Adds leading-zero suppression, per-digit blanking, blinking, decimal points and an optional hex mode.

---
 rtl/seg_pkg.sv | 32 +++
 rtl/seg_scan_driver_decode.sv | 38 +++
 rtl/seg_scan_driver.sv | 156 +++++++++++++++
 tb/tb_seg_scan_driver.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// seg_pkg: seven-segment bus type and glyph patterns shared by the scan driver.
package seg_pkg;

    // Segment bus. Bit 0 = a ... bit 6 = g. Active-low, so 0 = segment on.
    typedef logic [6:0] seg_t;

    // Glyphs below are written in a..g reading order (leftmost character = a).
    // This flips such a string into bus order, so that a lands on bit 0.
    function automatic seg_t abcdefg(input logic [6:0] s);
        return {s[0], s[1], s[2], s[3], s[4], s[5], s[6]};
    endfunction

    localparam seg_t SEG_OFF = 7'b1111111;

    localparam seg_t SEG_0 = abcdefg(7'b0000001);
    localparam seg_t SEG_1 = abcdefg(7'b1001111);
    localparam seg_t SEG_2 = abcdefg(7'b0010010);
    localparam seg_t SEG_3 = abcdefg(7'b0000110);
    localparam seg_t SEG_4 = abcdefg(7'b1001100);
    localparam seg_t SEG_5 = abcdefg(7'b0100100);
    localparam seg_t SEG_6 = abcdefg(7'b0100000);
    localparam seg_t SEG_7 = abcdefg(7'b0001111);
    localparam seg_t SEG_8 = abcdefg(7'b0000000);
    localparam seg_t SEG_9 = abcdefg(7'b0000100);
    localparam seg_t SEG_A = abcdefg(7'b0001000);
    localparam seg_t SEG_B = abcdefg(7'b1100000);
    localparam seg_t SEG_C = abcdefg(7'b0110001);
    localparam seg_t SEG_D = abcdefg(7'b1000010);
    localparam seg_t SEG_E = abcdefg(7'b0110000);
    localparam seg_t SEG_F = abcdefg(7'b0111000);

endpackage

// File: rtl/seg_scan_driver_decode.sv
// seg_decode: combinational 4-bit code to active-low segment pattern.
// In decimal mode code 10 shows "9" and codes 11..15 are blank. In hex mode
// codes 10..15 show A b C d E F.
module seg_decode
    import seg_pkg::*;
#(
    parameter int HEX_MODE = 0
) (
    input  logic [3:0] code,
    output seg_t       seg
);

    // Glyph lookup; the hex-mode branches are constant and fold away.
    always_comb begin
        // NOTE: a default ahead of the case keeps every path assigned, so no latch.
        seg = SEG_OFF;
        case (code)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            4'd10:   seg = (HEX_MODE != 0) ? SEG_A : SEG_9;
            4'd11:   seg = (HEX_MODE != 0) ? SEG_B : SEG_OFF;
            4'd12:   seg = (HEX_MODE != 0) ? SEG_C : SEG_OFF;
            4'd13:   seg = (HEX_MODE != 0) ? SEG_D : SEG_OFF;
            4'd14:   seg = (HEX_MODE != 0) ? SEG_E : SEG_OFF;
            4'd15:   seg = (HEX_MODE != 0) ? SEG_F : SEG_OFF;
            default: seg = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: time-multiplexed common-anode seven-segment driver.
// Each digit slot is SCAN_DIV cycles long: one dead cycle with everything
// off, then SCAN_DIV-1 lit cycles. Display data is taken from shadow
// registers written by a load strobe. Outputs are only re-registered on
// entry to a lit slot, so a load can never tear the digit being shown.
// seg bit 0 = a ... bit 6 = g, active-low.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int SCAN_DIV     = 50000,
    parameter int BLINK_FRAMES = 64,
    parameter int HEX_MODE     = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   blank_mask,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    input  logic [NUM_DIGITS-1:0]   dp_mask,
    input  logic                    lz_en,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_tick
);

    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam int BLK_W = $clog2(BLINK_FRAMES + 1);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_FRAMES - 1);

    logic [CNT_W-1:0]        cnt;
    logic [IDX_W-1:0]        idx;
    logic                    dead_q;     // this cycle is the dead cycle of a slot
    logic [BLK_W-1:0]        blink_cnt;
    logic                    blink_ph;

    logic [4*NUM_DIGITS-1:0] sh_digits;
    logic [NUM_DIGITS-1:0]   sh_blank;
    logic [NUM_DIGITS-1:0]   sh_blink;
    logic [NUM_DIGITS-1:0]   sh_dp;
    logic                    sh_lz;

    logic                    tick;
    logic [3:0]              cur_code;
    seg_t                    dec_seg;
    logic [NUM_DIGITS-1:0]   lz_dark;
    logic                    zero_above;
    logic                    dark;
    logic [NUM_DIGITS-1:0]   an_lit;

    assign tick     = (cnt == CNT_LAST);
    assign cur_code = sh_digits[4*idx +: 4];

    seg_decode #(.HEX_MODE(HEX_MODE)) u_decode (
        .code (cur_code),
        .seg  (dec_seg)
    );

    // Prescaler: free-running 0..SCAN_DIV-1, tick on the last count.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n)    cnt <= '0;
        else if (tick) cnt <= '0;
        else           cnt <= cnt + 1'b1;
    end

    // Scan index advances into the dead cycle; dead_q marks that cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx    <= IDX_LAST;
            dead_q <= 1'b0;
        end else begin
            dead_q <= tick;
            if (tick) idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end
    end

    // Shadow registers: atomic capture of all display inputs on load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_digits <= '0;
            sh_blank  <= '0;
            sh_blink  <= '0;
            sh_dp     <= '0;
            sh_lz     <= 1'b0;
        end else if (load) begin
            sh_digits <= digits;
            sh_blank  <= blank_mask;
            sh_blink  <= blink_mask;
            sh_dp     <= dp_mask;
            sh_lz     <= lz_en;
        end
    end

    // Blink timebase: counts frames, toggles phase every BLINK_FRAMES frames.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt <= '0;
            blink_ph  <= 1'b0;
        end else if (frame_tick) begin
            if (blink_cnt == BLK_LAST) begin
                blink_cnt <= '0;
                blink_ph  <= ~blink_ph;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end

    // Leading-zero chain: a digit is suppressed only if it and every digit
    // above it hold code 0. Masks do not affect the chain; digit 0 never goes dark.
    always_comb begin
        zero_above = 1'b1;
        lz_dark    = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_above = zero_above && (sh_digits[4*i +: 4] == 4'd0);
            lz_dark[i] = sh_lz && zero_above && (i != 0);
        end
    end

    // Darkness and anode select for the digit about to be lit.
    always_comb begin
        dark        = sh_blank[idx] | (sh_blink[idx] & blink_ph) | lz_dark[idx];
        an_lit      = '1;
        an_lit[idx] = 1'b0;
    end

    // Output registers: blank on the dead cycle, load the new digit on lit entry, hold otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg        <= SEG_OFF;
            dp         <= 1'b1;
            an         <= '1;
            frame_tick <= 1'b0;
        end else if (tick) begin
            seg        <= SEG_OFF;
            dp         <= 1'b1;
            an         <= '1;
            frame_tick <= 1'b0;
        end else if (dead_q) begin
            seg        <= dark ? SEG_OFF : dec_seg;
            dp         <= dark | ~sh_dp[idx];
            an         <= an_lit;
            frame_tick <= (idx == '0);
        end else begin
            frame_tick <= 1'b0;
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// tb_seg_scan_driver: directed bench for seg_scan_driver (4 digits, 4-cycle slots,
// 2-frame blink). A decimal-mode and a hex-mode instance run side by side.
module tb_seg_scan_driver;

    localparam int ND = 4;
    localparam int SD = 4;
    localparam int BF = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load;
    logic [15:0] digits;
    logic [3:0]  blank_mask, blink_mask, dp_mask;
    logic        lz_en;

    logic [6:0]  seg, seg_h;
    logic        dp, dp_h;
    logic [3:0]  an, an_h;
    logic        frame_tick, frame_tick_h;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    seg_scan_driver #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .BLINK_FRAMES(BF), .HEX_MODE(0)) u_dec (
        .clk(clk), .rst_n(rst_n), .load(load), .digits(digits),
        .blank_mask(blank_mask), .blink_mask(blink_mask), .dp_mask(dp_mask), .lz_en(lz_en),
        .seg(seg), .dp(dp), .an(an), .frame_tick(frame_tick)
    );

    seg_scan_driver #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .BLINK_FRAMES(BF), .HEX_MODE(1)) u_hex (
        .clk(clk), .rst_n(rst_n), .load(load), .digits(digits),
        .blank_mask(blank_mask), .blink_mask(blink_mask), .dp_mask(dp_mask), .lz_en(lz_en),
        .seg(seg_h), .dp(dp_h), .an(an_h), .frame_tick(frame_tick_h)
    );

    // a..g reading-order string -> segment bus (bit 0 = a).
    function automatic logic [6:0] p(input logic [6:0] s);
        return {s[0], s[1], s[2], s[3], s[4], s[5], s[6]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Wait (bounded) until the anode bus shows target, sampled on negedges.
    task automatic wait_an(input string name, input logic [3:0] target);
        int n = 0;
        while (an !== target && n < 64) begin
            @(negedge clk);
            n++;
        end
        check(name, an, target);
    endtask

    // Reach the first lit cycle of the next full slot of digit d.
    task automatic wait_slot(input int d);
        logic [3:0] sel;
        sel = 4'b1111;
        sel[d] = 1'b0;
        wait_an($sformatf("dead_before_d%0d", d), 4'b1111);
        wait_an($sformatf("slot_d%0d", d), sel);
    endtask

    task automatic apply(input logic [15:0] d, input logic [3:0] bl, input logic [3:0] bk,
                         input logic [3:0] dm, input logic lz);
        @(negedge clk);
        digits = d; blank_mask = bl; blink_mask = bk; dp_mask = dm; lz_en = lz;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [15:0] d;
        logic [3:0]  bl;
        logic [3:0]  dm;
        logic        lz;
        int          idx;
        logic [6:0]  es;   // expected decimal-mode segments
        logic        edp;
        logic [6:0]  eh;   // expected hex-mode segments
    } vec_t;

    vec_t tbl[25];

    initial begin
        logic [3:0] exp_an;
        logic       exp_ft;
        int         s, ph;

        rst_n = 1'b1; load = 1'b0; digits = '0;
        blank_mask = '0; blink_mask = '0; dp_mask = '0; lz_en = 1'b0;

        // ---------------- reset values ----------------
        #2 rst_n = 1'b0;
        #1;
        check("rst_seg", seg, 7'h7f);
        check("rst_dp", dp, 1'b1);
        check("rst_an", an, 4'hf);
        check("rst_ft", frame_tick, 1'b0);
        check("rst_seg_hex", seg_h, 7'h7f);
        check("rst_dp_hex", dp_h, 1'b1);
        repeat (3) @(negedge clk);
        check("rst_an_held", an, 4'hf);
        check("rst_an_hex_held", an_h, 4'hf);
        rst_n = 1'b1;

        // ---------------- scan timing from reset release ----------------
        for (int c = 1; c <= 36; c++) begin
            @(negedge clk);
            if (c < 4) begin
                exp_an = 4'hf;
                exp_ft = 1'b0;
            end else begin
                s  = (c - 4) / 4;
                ph = (c - 4) % 4;
                exp_an = 4'hf;
                if (ph != 0) exp_an[s % 4] = 1'b0;
                exp_ft = (ph == 1) && (s % 4 == 0);
            end
            check($sformatf("timing_an_c%0d", c), an, exp_an);
            check($sformatf("timing_ft_c%0d", c), frame_tick, exp_ft);
            if (c == 5) begin
                check("first_lit_seg_zero", seg, p(7'b0000001));
                check("first_lit_ft_hex", frame_tick_h, 1'b1);
            end
        end

        // ---------------- table-driven digit content ----------------
        tbl[0]  = '{16'h1234, 4'h0, 4'h0, 1'b0, 0, p(7'b1001100), 1'b1, p(7'b1001100)};
        tbl[1]  = '{16'h1234, 4'h0, 4'h0, 1'b0, 1, p(7'b0000110), 1'b1, p(7'b0000110)};
        tbl[2]  = '{16'h1234, 4'h0, 4'h0, 1'b0, 2, p(7'b0010010), 1'b1, p(7'b0010010)};
        tbl[3]  = '{16'h1234, 4'h0, 4'h0, 1'b0, 3, p(7'b1001111), 1'b1, p(7'b1001111)};
        tbl[4]  = '{16'h0070, 4'h0, 4'h0, 1'b1, 3, p(7'b1111111), 1'b1, p(7'b1111111)};
        tbl[5]  = '{16'h0070, 4'h0, 4'h0, 1'b1, 2, p(7'b1111111), 1'b1, p(7'b1111111)};
        tbl[6]  = '{16'h0070, 4'h0, 4'h0, 1'b1, 1, p(7'b0001111), 1'b1, p(7'b0001111)};
        tbl[7]  = '{16'h0070, 4'h0, 4'h0, 1'b1, 0, p(7'b0000001), 1'b1, p(7'b0000001)};
        tbl[8]  = '{16'h0070, 4'h0, 4'h0, 1'b0, 3, p(7'b0000001), 1'b1, p(7'b0000001)};
        tbl[9]  = '{16'h0070, 4'h0, 4'h0, 1'b0, 2, p(7'b0000001), 1'b1, p(7'b0000001)};
        tbl[10] = '{16'hAB00, 4'h0, 4'h0, 1'b0, 3, p(7'b0000100), 1'b1, p(7'b0001000)};
        tbl[11] = '{16'hAB00, 4'h0, 4'h0, 1'b0, 2, p(7'b1111111), 1'b1, p(7'b1100000)};
        tbl[12] = '{16'hCDEF, 4'h0, 4'h0, 1'b0, 3, p(7'b1111111), 1'b1, p(7'b0110001)};
        tbl[13] = '{16'hCDEF, 4'h0, 4'h0, 1'b0, 2, p(7'b1111111), 1'b1, p(7'b1000010)};
        tbl[14] = '{16'hCDEF, 4'h0, 4'h0, 1'b0, 1, p(7'b1111111), 1'b1, p(7'b0110000)};
        tbl[15] = '{16'hCDEF, 4'h0, 4'h0, 1'b0, 0, p(7'b1111111), 1'b1, p(7'b0111000)};
        tbl[16] = '{16'h1234, 4'h2, 4'h4, 1'b0, 2, p(7'b0010010), 1'b0, p(7'b0010010)};
        tbl[17] = '{16'h1234, 4'h2, 4'h4, 1'b0, 1, p(7'b1111111), 1'b1, p(7'b1111111)};
        tbl[18] = '{16'h1234, 4'h2, 4'h4, 1'b0, 0, p(7'b1001100), 1'b1, p(7'b1001100)};
        tbl[19] = '{16'h0300, 4'h4, 4'h0, 1'b1, 1, p(7'b0000001), 1'b1, p(7'b0000001)};
        tbl[20] = '{16'h0300, 4'h4, 4'h0, 1'b1, 2, p(7'b1111111), 1'b1, p(7'b1111111)};
        tbl[21] = '{16'h0000, 4'h0, 4'h0, 1'b1, 0, p(7'b0000001), 1'b1, p(7'b0000001)};
        tbl[22] = '{16'h0000, 4'h0, 4'h0, 1'b1, 1, p(7'b1111111), 1'b1, p(7'b1111111)};
        tbl[23] = '{16'h1000, 4'h0, 4'h0, 1'b1, 2, p(7'b0000001), 1'b1, p(7'b0000001)};
        tbl[24] = '{16'h1234, 4'h2, 4'h2, 1'b0, 1, p(7'b1111111), 1'b1, p(7'b1111111)};

        for (int k = 0; k < 25; k++) begin
            apply(tbl[k].d, tbl[k].bl, 4'h0, tbl[k].dm, tbl[k].lz);
            wait_slot(tbl[k].idx);
            check($sformatf("vec%0d_seg", k), seg, tbl[k].es);
            check($sformatf("vec%0d_dp", k), dp, tbl[k].edp);
            check($sformatf("vec%0d_seg_hex", k), seg_h, tbl[k].eh);
            @(negedge clk);
            check($sformatf("vec%0d_seg_hold", k), seg, tbl[k].es);
        end

        // ---------------- blinking, BLINK_FRAMES=2 ----------------
        do_reset();
        digits = 16'h0005; blank_mask = 4'h0; blink_mask = 4'b0001; dp_mask = 4'h0; lz_en = 1'b0;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        for (int f = 0; f <= 4; f++) begin
            wait_slot(0);
            check($sformatf("blink_f%0d_d0", f), seg,
                  (f == 2 || f == 3) ? p(7'b1111111) : p(7'b0100100));
            check($sformatf("blink_f%0d_an", f), an, 4'b1110);
            wait_slot(1);
            check($sformatf("blink_f%0d_d1", f), seg, p(7'b0000001));
        end

        // ---------------- asynchronous reset during a slot ----------------
        apply(16'h1234, 4'h0, 4'h0, 4'h0, 1'b0);
        wait_slot(2);
        check("pre_rst_d2", seg, p(7'b0010010));
        digits = 16'h9999;
        load = 1'b1;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_seg", seg, 7'h7f);
        check("async_rst_an", an, 4'hf);
        check("async_rst_dp", dp, 1'b1);
        check("async_rst_ft", frame_tick, 1'b0);
        @(negedge clk);
        load = 1'b0;
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("post_rst_dead", an, 4'hf);
        @(negedge clk);
        check("post_rst_an", an, 4'b1110);
        check("post_rst_seg", seg, p(7'b0000001));
        check("post_rst_ft", frame_tick, 1'b1);
        wait_slot(3);
        check("post_rst_shadow_clear", seg, p(7'b0000001));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
